i2c_register_bridge: RTL and testbench

- Register-file bridge directly downstream of the I2C slave engine; consumes its user interface (read_req, data_valid, data_from_master, write_cycle_count) and drives data_to_master back to it.
- Implements the standard "pointer + auto-increment" byte register map seen by the BMC/host over I2C.
- Exposes all registers flat to FPGA logic, plus write/read strobes and a hardware update port for read-only status registers.

---
 rtl/i2c_register_bridge.sv | 70 +++++++
 tb/tb_i2c_register_bridge.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/i2c_register_bridge.sv
// i2c_register_bridge: pointer + auto-increment byte register map behind the I2C slave engine.
module i2c_register_bridge #(
  parameter int ADDR_WIDTH = 4,
  parameter int RO_BASE    = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      read_req,
  input  logic                      data_valid,
  input  logic [7:0]                data_from_master,
  input  logic [7:0]                write_cycle_count,
  output logic [7:0]                data_to_master,
  output logic [8*(2**ADDR_WIDTH)-1:0] regs_flat,
  output logic                      wr_strobe,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [7:0]                wr_data,
  output logic                      rd_strobe,
  output logic [ADDR_WIDTH-1:0]     rd_addr,
  input  logic                      hw_wr_en,
  input  logic [ADDR_WIDTH-1:0]     hw_wr_addr,
  input  logic [7:0]                hw_wr_data
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] RO = (ADDR_WIDTH+1)'(RO_BASE);
  logic [7:0]            regs_q [NUM_REGS];
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, wr_addr_q, rd_addr_q;
  logic [7:0]            dtm_q, wr_data_q;
  logic                  wr_strobe_q, rd_strobe_q, wr_d, rd_d, hw_d;
  always_comb begin
    wr_d  = data_valid && write_cycle_count != 8'd1 && ({1'b0, ptr_q} < RO);
    rd_d  = read_req && !data_valid;
    hw_d  = hw_wr_en && ({1'b0, hw_wr_addr} >= RO);
    ptr_d = data_valid ? (write_cycle_count == 8'd1 ? data_from_master[ADDR_WIDTH-1:0] : ptr_q + 1'b1)
          : read_req ? ptr_q + 1'b1 : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      ptr_q       <= '0;
      dtm_q       <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_strobe_q <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      // I2C writes land below RO, hw writes at/above it, so the two never collide
      if (wr_d) regs_q[ptr_q] <= data_from_master;
      if (hw_d) regs_q[hw_wr_addr] <= hw_wr_data;
      ptr_q       <= ptr_d;
      dtm_q       <= regs_q[ptr_q];
      wr_strobe_q <= wr_d;
      rd_strobe_q <= rd_d;
      if (wr_d) begin
        wr_addr_q <= ptr_q;
        wr_data_q <= data_from_master;
      end
      if (rd_d) rd_addr_q <= ptr_q;
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_flat[8*i +: 8] = regs_q[i];
  end
  assign data_to_master = dtm_q;
  assign wr_strobe      = wr_strobe_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign rd_strobe      = rd_strobe_q;
  assign rd_addr        = rd_addr_q;
endmodule

// File: tb/tb_i2c_register_bridge.sv
// tb_i2c_register_bridge: directed scenario tests for the I2C register bridge.
module tb_i2c_register_bridge;
  logic         clk = 0, rst = 1, read_req = 0, data_valid = 0, hw_wr_en = 0;
  logic [7:0]   data_from_master = 0, write_cycle_count = 0, hw_wr_data = 0;
  logic [3:0]   hw_wr_addr = 0;
  logic [7:0]   data_to_master, wr_data;
  logic [127:0] regs_flat;
  logic         wr_strobe, rd_strobe;
  logic [3:0]   wr_addr, rd_addr;
  int checks = 0, errors = 0;

  i2c_register_bridge #(.ADDR_WIDTH(4), .RO_BASE(12)) dut (
    .clk(clk), .rst(rst), .read_req(read_req), .data_valid(data_valid),
    .data_from_master(data_from_master), .write_cycle_count(write_cycle_count),
    .data_to_master(data_to_master), .regs_flat(regs_flat),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_strobe(rd_strobe), .rd_addr(rd_addr),
    .hw_wr_en(hw_wr_en), .hw_wr_addr(hw_wr_addr), .hw_wr_data(hw_wr_data));

  always #5 clk = ~clk;

  function automatic logic [7:0] reg_at(input int i);
    return regs_flat[8*i +: 8];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wbyte(input logic [7:0] c, input logic [7:0] d);
    data_valid = 1; write_cycle_count = c; data_from_master = d;
    tick;
    data_valid = 0;
  endtask

  task automatic rbyte(output logic [7:0] got);
    got = data_to_master;
    read_req = 1;
    tick;
    read_req = 0;
  endtask

  task automatic test_reset;
    tick; tick; rst = 0;
    checks++; if (regs_flat !== '0) begin errors++; $display("FAIL reset_regs got %h exp 0", regs_flat); end
    checks++; if (data_to_master !== 8'h00) begin errors++; $display("FAIL reset_dtm got %h exp 00", data_to_master); end
    checks++; if ({wr_strobe, rd_strobe} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b exp 00", {wr_strobe, rd_strobe}); end
  endtask

  task automatic test_write_burst;
    logic [7:0] got;
    wbyte(8'd1, 8'h03);
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL wb_ptr_nostrobe got %b exp 0", wr_strobe); end
    wbyte(8'd2, 8'hAA);
    checks++; if ({wr_strobe, wr_addr, wr_data} !== {1'b1, 4'd3, 8'hAA}) begin errors++; $display("FAIL wb_strobe1 got %b/%0d/%h exp 1/3/aa", wr_strobe, wr_addr, wr_data); end
    wbyte(8'd3, 8'hBB);
    checks++; if ({wr_strobe, wr_addr, wr_data} !== {1'b1, 4'd4, 8'hBB}) begin errors++; $display("FAIL wb_strobe2 got %b/%0d/%h exp 1/4/bb", wr_strobe, wr_addr, wr_data); end
    tick;
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL wb_strobe_pulse got %b exp 0", wr_strobe); end
    checks++; if ({reg_at(3), reg_at(4)} !== 16'hAABB) begin errors++; $display("FAIL wb_regs got %h exp aabb", {reg_at(3), reg_at(4)}); end
    rbyte(got);
    checks++; if ({rd_strobe, rd_addr} !== {1'b1, 4'd5}) begin errors++; $display("FAIL wb_ptr got %b/%0d exp 1/5", rd_strobe, rd_addr); end
    tick;
  endtask

  task automatic test_read_burst;
    logic [7:0] got;
    logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
    wbyte(8'd1, 8'h02); wbyte(8'd2, 8'h11); wbyte(8'd3, 8'h22); wbyte(8'd4, 8'h33);
    tick;
    wbyte(8'd1, 8'h02);
    tick; tick;
    for (int i = 0; i < 3; i++) begin
      rbyte(got);
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL rd_data%0d got %h exp %h", i, got, exp[i]); end
      checks++; if ({rd_strobe, rd_addr} !== {1'b1, 4'(2 + i)}) begin errors++; $display("FAIL rd_addr%0d got %b/%0d exp 1/%0d", i, rd_strobe, rd_addr, 2 + i); end
      tick;
      checks++; if (rd_strobe !== 1'b0) begin errors++; $display("FAIL rd_pulse%0d got %b exp 0", i, rd_strobe); end
      tick;
    end
    rbyte(got);
    checks++; if (rd_addr !== 4'd5) begin errors++; $display("FAIL rd_ptr_end got %0d exp 5", rd_addr); end
    tick;
  endtask

  task automatic test_ro_wrap;
    wbyte(8'd1, 8'h0F);
    wbyte(8'd2, 8'h5A);
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL ro_nostrobe got %b exp 0", wr_strobe); end
    wbyte(8'd3, 8'h6B);
    checks++; if ({wr_strobe, wr_addr, wr_data} !== {1'b1, 4'd0, 8'h6B}) begin errors++; $display("FAIL wrap_strobe got %b/%0d/%h exp 1/0/6b", wr_strobe, wr_addr, wr_data); end
    tick;
    checks++; if ({reg_at(15), reg_at(0)} !== 16'h006B) begin errors++; $display("FAIL ro_wrap_regs got %h exp 006b", {reg_at(15), reg_at(0)}); end
  endtask

  task automatic test_hw_write;
    logic [7:0] got;
    hw_wr_en = 1; hw_wr_addr = 4'd12; hw_wr_data = 8'hC3;
    tick;
    hw_wr_addr = 4'd2; hw_wr_data = 8'h99;
    tick;
    hw_wr_en = 0;
    checks++; if ({reg_at(12), reg_at(2)} !== 16'hC311) begin errors++; $display("FAIL hw_regs got %h exp c311", {reg_at(12), reg_at(2)}); end
    wbyte(8'd1, 8'h0C);
    tick; tick;
    rbyte(got);
    checks++; if ({got, rd_addr} !== {8'hC3, 4'd12}) begin errors++; $display("FAIL hw_read got %h/%0d exp c3/12", got, rd_addr); end
    tick;
  endtask

  task automatic test_pointer_upper;
    logic [7:0] got;
    wbyte(8'd1, 8'hF4);
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL ptr_nostrobe got %b exp 0", wr_strobe); end
    tick; tick;
    checks++; if (data_to_master !== 8'h33) begin errors++; $display("FAIL ptr_upper_dtm got %h exp 33", data_to_master); end
    data_valid = 1; write_cycle_count = 8'd1; data_from_master = 8'h07; read_req = 1;
    tick;
    data_valid = 0; read_req = 0;
    checks++; if (rd_strobe !== 1'b0) begin errors++; $display("FAIL dv_priority_strobe got %b exp 0", rd_strobe); end
    tick;
    rbyte(got);
    checks++; if (rd_addr !== 4'd7) begin errors++; $display("FAIL dv_priority_ptr got %0d exp 7", rd_addr); end
    tick;
  endtask

  task automatic test_reset_mid;
    logic [7:0] got;
    wbyte(8'd1, 8'h03);
    rst = 1; data_valid = 1; write_cycle_count = 8'd2; data_from_master = 8'h77;
    tick;
    rst = 0; data_valid = 0;
    checks++; if (regs_flat !== '0) begin errors++; $display("FAIL rstmid_regs got %h exp 0", regs_flat); end
    checks++; if ({wr_strobe, rd_strobe, wr_addr, wr_data, rd_addr, data_to_master} !== '0) begin errors++; $display("FAIL rstmid_outs got %b/%b/%0d/%h/%0d/%h exp all 0", wr_strobe, rd_strobe, wr_addr, wr_data, rd_addr, data_to_master); end
    tick;
    rbyte(got);
    checks++; if ({got, rd_strobe, rd_addr} !== {8'h00, 1'b1, 4'd0}) begin errors++; $display("FAIL rstmid_read got %h/%b/%0d exp 00/1/0", got, rd_strobe, rd_addr); end
  endtask

  initial begin
    test_reset;
    test_write_burst;
    test_read_burst;
    test_ro_wrap;
    test_hw_write;
    test_pointer_upper;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
